// File: rtl/fpdivit.sv
// Fixed-point iterative divider: c = (a << d) / b, truncated toward zero.
// Restoring division, one quotient bit per cycle, snd/rcv val/rdy handshake.
module fpdivit #(
  parameter int n    = 32,
  parameter int d    = 16,
  parameter bit sign = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         snd_val,
  output logic         snd_rdy,
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  output logic         rcv_val,
  input  logic         rcv_rdy,
  output logic [n-1:0] c,
  output logic         err
);

  localparam int W  = n + d;
  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [n-1:0] MAX_POS = {1'b0, {(n-1){1'b1}}};
  localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};
  localparam logic [n-1:0] ALL_ONE = {n{1'b1}};

  logic [1:0]    r_state;
  logic [n-1:0]  r_bmag;
  logic [W-1:0]  r_num;
  logic [n-1:0]  r_rem;
  logic [W-1:0]  r_quo;
  logic [CW-1:0] r_cnt;
  logic          r_neg;
  logic          r_aneg;
  logic          r_bzero;
  logic          r_snd_rdy;
  logic          r_rcv_val;
  logic [n-1:0]  r_c;
  logic          r_err;

  logic [n-1:0]  w_amag;
  logic [n-1:0]  w_bmag;
  logic          w_neg;
  logic [n:0]    w_rem_sh;
  logic [n:0]    w_rem_diff;
  logic          w_ge;
  logic          w_ovf;
  logic [n-1:0]  w_c_fix;
  logic          w_err_fix;

  // Operand magnitudes and result sign at accept
  always_comb begin
    w_amag = a;
    w_bmag = b;
    w_neg  = 1'b0;
    if (sign && a[n-1]) begin
      w_amag = -a;
    end else begin
      w_amag = a;
    end
    if (sign && b[n-1]) begin
      w_bmag = -b;
    end else begin
      w_bmag = b;
    end
    if (sign) begin
      w_neg = a[n-1] ^ b[n-1];
    end else begin
      w_neg = 1'b0;
    end
  end

  // One restoring step; the difference can never exceed n bits in magnitude,
  // so its top bit doubles as the borrow.
  always_comb begin
    w_rem_sh   = {r_rem, r_num[W-1]};
    w_rem_diff = w_rem_sh - {1'b0, r_bmag};
    w_ge       = ~w_rem_diff[n];
  end

  // Saturation, divide-by-zero and final sign correction
  always_comb begin
    w_ovf     = 1'b0;
    w_c_fix   = r_quo[n-1:0];
    w_err_fix = 1'b0;
    if (!sign) begin
      w_ovf = |r_quo[W-1:n];
    end else if (r_neg) begin
      w_ovf = (|r_quo[W-1:n]) | (r_quo[n-1] & (|r_quo[n-2:0]));
    end else begin
      w_ovf = (|r_quo[W-1:n]) | r_quo[n-1];
    end
    if (r_bzero) begin
      w_err_fix = 1'b1;
      w_c_fix   = sign ? (r_aneg ? MIN_NEG : MAX_POS) : ALL_ONE;
    end else if (w_ovf) begin
      w_err_fix = 1'b1;
      w_c_fix   = sign ? (r_neg ? MIN_NEG : MAX_POS) : ALL_ONE;
    end else begin
      w_err_fix = 1'b0;
      w_c_fix   = r_neg ? -r_quo[n-1:0] : r_quo[n-1:0];
    end
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_bmag    <= '0;
      r_num     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_aneg    <= 1'b0;
      r_bzero   <= 1'b0;
      r_snd_rdy <= 1'b1;
      r_rcv_val <= 1'b0;
      r_c       <= '0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (snd_val) begin
            r_bmag    <= w_bmag;
            r_num     <= {w_amag, {d{1'b0}}};
            r_rem     <= '0;
            r_quo     <= '0;
            r_cnt     <= '0;
            r_neg     <= w_neg;
            r_aneg    <= sign & a[n-1];
            r_bzero   <= (b == '0);
            r_snd_rdy <= 1'b0;
            r_state   <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_ge ? w_rem_diff[n-1:0] : w_rem_sh[n-1:0];
          r_quo <= {r_quo[W-2:0], w_ge};
          r_num <= {r_num[W-2:0], 1'b0};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_c       <= w_c_fix;
          r_err     <= w_err_fix;
          r_rcv_val <= 1'b1;
          r_state   <= S_DONE;
        end
        S_DONE: begin
          if (rcv_rdy) begin
            r_rcv_val <= 1'b0;
            r_snd_rdy <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_snd_rdy <= 1'b1;
          r_rcv_val <= 1'b0;
        end
      endcase
    end
  end

  assign snd_rdy = r_snd_rdy;
  assign rcv_val = r_rcv_val;
  assign c       = r_c;
  assign err     = r_err;

endmodule

// File: tb/tb_fpdivit.sv
// Directed bench for fpdivit: table of signed vectors, an unsigned instance,
// backpressure / ignored-input sequence and mid-operation reset.
module tb_fpdivit;

  logic        clk;
  logic        reset;
  logic        snd_val, snd_rdy, rcv_val, rcv_rdy, err;
  logic [31:0] a, b, c;
  logic        u_snd_val, u_snd_rdy, u_rcv_val, u_rcv_rdy, u_err;
  logic [31:0] u_a, u_b, u_c;

  int total = 0;
  int bad   = 0;

  fpdivit #(.n(32), .d(16), .sign(1'b1)) u_dut (
    .clk(clk), .reset(reset), .snd_val(snd_val), .snd_rdy(snd_rdy),
    .a(a), .b(b), .rcv_val(rcv_val), .rcv_rdy(rcv_rdy), .c(c), .err(err)
  );

  fpdivit #(.n(32), .d(16), .sign(1'b0)) u_dut_u (
    .clk(clk), .reset(reset), .snd_val(u_snd_val), .snd_rdy(u_snd_rdy),
    .a(u_a), .b(u_b), .rcv_val(u_rcv_val), .rcv_rdy(u_rcv_rdy), .c(u_c), .err(u_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Full transaction on the signed instance; samples on negedge.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input int hold,
                       input bit noise, output logic [31:0] oc, output logic oerr,
                       output int lat);
    int k;
    bit busy_bad;
    bit stab_bad;
    k = 0;
    while (!snd_rdy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("idle_wait", {63'd0, snd_rdy}, 64'd1);
    a = ta; b = tbv; snd_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    snd_val = 1'b0;
    lat = 0;
    busy_bad = 1'b0;
    while (!rcv_val && lat < 200) begin
      if (snd_rdy) busy_bad = 1'b1;
      if (noise) begin
        snd_val = lat[0];
        a = 32'h0006_0000;
        b = 32'h0000_0001;
      end
      @(negedge clk);
      lat++;
    end
    snd_val = 1'b0;
    chk("snd_rdy_busy", {63'd0, busy_bad}, 64'd0);
    oc = c;
    oerr = err;
    stab_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        snd_val = i[0];
        a = 32'h0007_0000;
        b = 32'h0000_0003;
      end
      @(negedge clk);
      if (c !== oc || err !== oerr || rcv_val !== 1'b1) stab_bad = 1'b1;
    end
    if (hold > 0) chk("hold_stable", {63'd0, stab_bad}, 64'd0);
    snd_val = 1'b0;
    rcv_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rcv_rdy = 1'b0;
    chk("snd_rdy_after", {62'd0, snd_rdy, rcv_val}, 64'd2);
    chk("c_held", {32'd0, c}, {32'd0, oc});
  endtask

  task automatic u_op(input logic [31:0] ta, input logic [31:0] tbv,
                      input logic [31:0] ec, input logic ee);
    int lat;
    u_a = ta; u_b = tbv; u_snd_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_snd_val = 1'b0;
    lat = 0;
    while (!u_rcv_val && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("u_lat", 64'(lat), 64'd49);
    chk("u_c", {32'd0, u_c}, {32'd0, ec});
    chk("u_err", {63'd0, u_err}, {63'd0, ee});
    u_rcv_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    u_rcv_rdy = 1'b0;
  endtask

  initial begin
    vec_t        vecs[14];
    logic [31:0] rc;
    logic        re;
    int          lat;

    vecs[0]  = '{32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0};
    vecs[1]  = '{32'h0001_0000, 32'h0003_0000, 32'h0000_5555, 1'b0};
    vecs[2]  = '{32'hFFFF_0000, 32'h0003_0000, 32'hFFFF_AAAB, 1'b0};
    vecs[3]  = '{32'hFFFD_0000, 32'hFFFE_0000, 32'h0001_8000, 1'b0};
    vecs[4]  = '{32'h0001_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[5]  = '{32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
    vecs[6]  = '{32'h7FFF_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1};
    vecs[7]  = '{32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0};
    vecs[8]  = '{32'h0000_0000, 32'hFFFE_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[10] = '{32'h8000_0000, 32'hFFFF_0000, 32'h7FFF_FFFF, 1'b1};
    vecs[11] = '{32'h4000_0000, 32'h0000_8000, 32'h7FFF_FFFF, 1'b1};
    vecs[12] = '{32'hC000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0};
    vecs[13] = '{32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_8000, 1'b0};

    reset = 1'b1;
    snd_val = 1'b0; rcv_rdy = 1'b0; a = '0; b = '0;
    u_snd_val = 1'b0; u_rcv_rdy = 1'b0; u_a = '0; u_b = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {29'd0, snd_rdy, rcv_val, err, c}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].a, vecs[i].b, 0, 1'b0, rc, re, lat);
      chk($sformatf("vec%0d_c", i), {32'd0, rc}, {32'd0, vecs[i].c});
      chk($sformatf("vec%0d_err", i), {63'd0, re}, {63'd0, vecs[i].err});
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'd49);
    end

    // Backpressure with junk operands offered during CALC and DONE
    do_op(32'h0003_0000, 32'h0002_0000, 10, 1'b1, rc, re, lat);
    chk("bp_c", {32'd0, rc}, 64'h0001_8000);
    chk("bp_err", {63'd0, re}, 64'd0);
    chk("bp_lat", 64'(lat), 64'd49);

    // Reset 20 cycles into CALC, while c still holds the previous result
    a = 32'h0003_0000; b = 32'h0002_0000; snd_val = 1'b1;
    @(posedge clk);
    @(negedge clk);
    snd_val = 1'b0;
    repeat (20) @(negedge clk);
    chk("pre_reset_busy", {63'd0, snd_rdy}, 64'd0);
    reset = 1'b1;
    #1;
    chk("mid_reset", {29'd0, snd_rdy, rcv_val, err, c}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_op(32'h0006_0000, 32'h0002_0000, 0, 1'b0, rc, re, lat);
    chk("post_reset_c", {32'd0, rc}, 64'h0003_0000);
    chk("post_reset_err", {63'd0, re}, 64'd0);
    chk("post_reset_lat", 64'(lat), 64'd49);

    // Unsigned instance
    u_op(32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b1);
    u_op(32'hFFFF_0000, 32'h0002_0000, 32'h7FFF_8000, 1'b0);
    u_op(32'h0001_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
    u_op(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
